// File: rtl/tick_to_level.sv
// Turns single-cycle ticks into a held level: either a fixed-length one-shot
// pulse followed by a forced low gap, or a toggle of the level per tick.
module tick_to_level #(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode,
  output logic       level,
  output logic       busy,
  output logic       dropped,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] HIGH_LOAD = 16'(HIGH_CYCLES - 1);
  // Only used when GAP_CYCLES > 0, so the wrap at zero is harmless.
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        busy_q, busy_d;
  logic        dropped_q, dropped_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  // Mode is only consulted in IDLE; HIGH and GAP run to completion regardless.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tick && !mode) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (tick && RETRIGGER) begin
          cnt_d = HIGH_LOAD;
        end else if (cnt_q == 16'd0) begin
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  always_comb begin
    level_d   = level_q;
    dropped_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Leaving toggle mode with level high clears it unless a pulse starts.
        if (mode) level_d = level_q ^ tick;
        else      level_d = tick;
      end
      ST_HIGH: begin
        level_d   = (state_d == ST_HIGH);
        dropped_d = tick && !RETRIGGER;
      end
      ST_GAP: begin
        level_d   = 1'b0;
        dropped_d = tick;
      end
      default: begin
        level_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign level     = level_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tick_to_level.sv
// Directed-vector bench for tick_to_level: three parameterisations share one
// stimulus bus; a scoreboard queue holds the expected outputs per cycle.
module tb_tick_to_level;

  logic clk;
  logic reset;
  logic tick;
  logic mode;

  logic       a_level, a_busy, a_dropped;
  logic       r_level, r_busy, r_dropped;
  logic       c_level, c_busy, c_dropped;
  logic [1:0] a_state, r_state, c_state;

  // Entry layout: {sel[1:0], level, busy, dropped}; sel 0=default, 1=retrigger, 2=1/0 timing.
  logic [4:0] exp_q[$];
  string      name_q[$];
  int         checks;
  int         errors;

  tick_to_level dut_a (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode),
    .level(a_level), .busy(a_busy), .dropped(a_dropped), .dbg_state(a_state)
  );

  tick_to_level #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .RETRIGGER(1'b1)) dut_r (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode),
    .level(r_level), .busy(r_busy), .dropped(r_dropped), .dbg_state(r_state)
  );

  tick_to_level #(.HIGH_CYCLES(1), .GAP_CYCLES(0), .RETRIGGER(1'b0)) dut_c (
    .clk(clk), .reset(reset), .tick(tick), .mode(mode),
    .level(c_level), .busy(c_busy), .dropped(c_dropped), .dbg_state(c_state)
  );

  // Clock and initial input values.
  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    tick  = 1'b0;
    mode  = 1'b0;
    checks = 0;
    errors = 0;
    forever #5 clk = ~clk;
  end

  // Driver: char i of each string is the input at edge i and the expected
  // output value right after edge i.
  task automatic run(input string name, input logic [1:0] sel,
                     input string tk, input string md, input string rs,
                     input string lv, input string bs, input string dp);
    for (int i = 0; i < tk.len(); i++) begin
      tick  = (tk[i] == "1");
      mode  = (md[i] == "1");
      reset = (rs[i] == "1");
      @(posedge clk);
      #1;
      exp_q.push_back({sel, lv[i] == "1", bs[i] == "1", dp[i] == "1"});
      name_q.push_back($sformatf("%s[%0d]", name, i));
    end
  endtask

  // Monitor: outputs are stable between edges, compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [4:0] e;
      logic [2:0] act;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[4:3])
        2'd0:    act = {a_level, a_busy, a_dropped};
        2'd1:    act = {r_level, r_busy, r_dropped};
        default: act = {c_level, c_busy, c_dropped};
      endcase
      checks++;
      if (act !== e[2:0]) begin
        errors++;
        $display("FAIL %s dut=%0d {level,busy,dropped} got=%b want=%b", nm, e[4:3], act, e[2:0]);
      end
    end
  end

  initial begin
    int wait_cycles;
    // Single pulse; the tick at the reset edge is discarded.
    run("single",  2'd0, "1010000000", "0000000000", "1000000000",
                         "0011110000", "0011111100", "0000000000");
    // Ticks in HIGH and in GAP dropped, tick after GAP accepted.
    run("drop",    2'd0, "00101001010000000", "00000000000000000", "10000000000000000",
                         "00111100011110000", "00111111011111100", "00001001000000000");
    // Tick on the last GAP cycle dropped; mode change mid-pulse ignored.
    run("lastgap", 2'd0, "001000001000", "000111110000", "100000000000",
                         "001111000000", "001111110000", "000000001000");
    // Retrigger extends the pulse to 7 cycles.
    run("retrig",  2'd1, "0010010000000", "0000000000000", "1000000000000",
                         "0011111110000", "0011111111100", "0000000000000");
    // Toggle mode, then switch to one-shot with level high and no tick.
    run("toggle",  2'd0, "0010011000", "1111111100", "1000000000",
                         "0011101100", "0000000000", "0000000000");
    // Switch toggle->one-shot with a tick in the same cycle.
    run("switch",  2'd0, "00110000000", "11100000000", "10000000000",
                         "00111110000", "00011111100", "00000000000");
    // Reset mid-HIGH (with coincident tick) and mid-GAP.
    run("reset",   2'd0, "0010110000000", "0000000000000", "1000100000100",
                         "0011011110000", "0011011111000", "0000000000000");
    // HIGH=1, GAP=0: alternate ticks, then ticks every cycle.
    run("b2b",     2'd2, "00101010101111110", "00000000000000000", "10000000000000000",
                         "00101010101010100", "00101010101010100", "00000000000101010");
    tick  = 1'b0;
    reset = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 5) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
